// File: rtl/regfile_stage_if.sv
// rtl/regfile_stage_if.sv - decode-side bundle for the register file / decode-to-execute stage
interface regfile_stage_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16
);
  logic               stall;
  logic               flush;
  logic               valid_in;
  logic               ls_in;
  logic [INSTR_W-1:0] instr_in;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr1;
  logic [ADDR_W-1:0]  rd_addr2;
  logic               wr_en1;
  logic               wr_en2;
  logic [ADDR_W-1:0]  wr_addr1;
  logic [ADDR_W-1:0]  wr_addr2;
  logic [DATA_W-1:0]  wr_data1;
  logic [DATA_W-1:0]  wr_data2;
  logic [DATA_W-1:0]  rd_data1;
  logic [DATA_W-1:0]  rd_data2;
  logic [INSTR_W-1:0] instr_out;
  logic               valid_out;
  logic               ls_out;
  logic [ADDR_W-1:0]  rd_addr1_out;
  logic [ADDR_W-1:0]  rd_addr2_out;

  modport master (
    output stall, flush, valid_in, ls_in, instr_in, rd_en, rd_addr1, rd_addr2,
           wr_en1, wr_en2, wr_addr1, wr_addr2, wr_data1, wr_data2,
    input  rd_data1, rd_data2, instr_out, valid_out, ls_out, rd_addr1_out, rd_addr2_out
  );

  modport slave (
    input  stall, flush, valid_in, ls_in, instr_in, rd_en, rd_addr1, rd_addr2,
           wr_en1, wr_en2, wr_addr1, wr_addr2, wr_data1, wr_data2,
    output rd_data1, rd_data2, instr_out, valid_out, ls_out, rd_addr1_out, rd_addr2_out
  );
endinterface

// File: rtl/regfile_stage.sv
// rtl/regfile_stage.sv - two-write/two-read register file fused with the decode-to-execute pipeline register
module regfile_stage #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 4,
  parameter int                INSTR_W  = 16,
  parameter bit                ZERO_REG = 1'b1,
  parameter int                SP_IDX   = 13,
  parameter logic [DATA_W-1:0] SP_INIT  = 16'h8000
) (
  input logic              clk,
  input logic              reset,
  regfile_stage_if.slave   bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_next1;
  logic [DATA_W-1:0] rd_next2;
  logic              wr_ok1;
  logic              wr_ok2;

  // Port 2 is checked first so it wins both in the bypass and in the array.
  function automatic logic [DATA_W-1:0] bypass(input logic [ADDR_W-1:0] addr);
    if (ZERO_REG && addr == '0)
      return '0;
    else if (bus.wr_en2 && addr == bus.wr_addr2)
      return bus.wr_data2;
    else if (bus.wr_en1 && addr == bus.wr_addr1)
      return bus.wr_data1;
    else
      return regs[addr];
  endfunction

  always_comb begin
    rd_next1 = bypass(bus.rd_addr1);
    rd_next2 = bypass(bus.rd_addr2);
    wr_ok1   = bus.wr_en1 && !(ZERO_REG && bus.wr_addr1 == '0);
    wr_ok2   = bus.wr_en2 && !(ZERO_REG && bus.wr_addr2 == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == 0 || i == NUM_REGS - 1) ? '0 :
                   (i == SP_IDX)                 ? SP_INIT :
                                                   DATA_W'(i);
      end
      bus.rd_data1     <= '0;
      bus.rd_data2     <= '0;
      bus.instr_out    <= '0;
      bus.valid_out    <= 1'b0;
      bus.ls_out       <= 1'b0;
      bus.rd_addr1_out <= '0;
      bus.rd_addr2_out <= '0;
    end else begin
      if (wr_ok1)
        regs[bus.wr_addr1] <= bus.wr_data1;
      if (wr_ok2)
        regs[bus.wr_addr2] <= bus.wr_data2;

      if (bus.rd_en && !bus.stall) begin
        bus.rd_data1 <= rd_next1;
        bus.rd_data2 <= rd_next2;
      end

      // Flush overrides stall on the pipeline register only; read data is left alone.
      if (bus.flush) begin
        bus.instr_out    <= '0;
        bus.valid_out    <= 1'b0;
        bus.ls_out       <= 1'b0;
        bus.rd_addr1_out <= '0;
        bus.rd_addr2_out <= '0;
      end else if (!bus.stall) begin
        bus.instr_out    <= bus.instr_in;
        bus.valid_out    <= bus.valid_in;
        bus.ls_out       <= bus.ls_in;
        bus.rd_addr1_out <= bus.rd_addr1;
        bus.rd_addr2_out <= bus.rd_addr2;
      end
    end
  end
endmodule

// File: tb/tb_regfile_stage.sv
// tb/tb_regfile_stage.sv - directed and randomized bench for regfile_stage
module tb_regfile_stage;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  regfile_stage_if #(.DATA_W(16), .ADDR_W(4), .INSTR_W(16)) bus ();

  regfile_stage #(
    .DATA_W(16), .ADDR_W(4), .INSTR_W(16),
    .ZERO_REG(1'b1), .SP_IDX(13), .SP_INIT(16'h8000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] m_regs [16];
  logic [15:0] m_rd1, m_rd2, m_instr;
  logic        m_valid, m_ls;
  logic [3:0]  m_a1o, m_a2o;

  function automatic logic [15:0] reset_value(input int i);
    if (i == 0 || i == 15) return 16'h0000;
    if (i == 13)           return 16'h8000;
    return 16'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset        = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.valid_in = 1'b0;
    bus.ls_in    = 1'b0;
    bus.instr_in = '0;
    bus.rd_en    = 1'b0;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    bus.wr_en1   = 1'b0;
    bus.wr_en2   = 1'b0;
    bus.wr_addr1 = '0;
    bus.wr_addr2 = '0;
    bus.wr_data1 = '0;
    bus.wr_data2 = '0;
  endtask

  // Reference: reads see the register file as it stands after this cycle's writes.
  task automatic model_step();
    logic [15:0] after [16];
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] = reset_value(i);
      m_rd1 = 0; m_rd2 = 0; m_instr = 0; m_valid = 0; m_ls = 0; m_a1o = 0; m_a2o = 0;
      return;
    end
    after = m_regs;
    if (bus.wr_en1 && bus.wr_addr1 != 0) after[bus.wr_addr1] = bus.wr_data1;
    if (bus.wr_en2 && bus.wr_addr2 != 0) after[bus.wr_addr2] = bus.wr_data2;
    if (bus.rd_en && !bus.stall) begin
      m_rd1 = after[bus.rd_addr1];
      m_rd2 = after[bus.rd_addr2];
    end
    if (bus.flush) begin
      m_instr = 0; m_valid = 0; m_ls = 0; m_a1o = 0; m_a2o = 0;
    end else if (!bus.stall) begin
      m_instr = bus.instr_in; m_valid = bus.valid_in; m_ls = bus.ls_in;
      m_a1o = bus.rd_addr1; m_a2o = bus.rd_addr2;
    end
    m_regs = after;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".rd_data1"},  bus.rd_data1,     m_rd1);
    check({tag, ".rd_data2"},  bus.rd_data2,     m_rd2);
    check({tag, ".instr_out"}, bus.instr_out,    m_instr);
    check({tag, ".valid_out"}, bus.valid_out,    m_valid);
    check({tag, ".ls_out"},    bus.ls_out,       m_ls);
    check({tag, ".rd_addr1"},  bus.rd_addr1_out, m_a1o);
    check({tag, ".rd_addr2"},  bus.rd_addr2_out, m_a2o);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'hxxxx;
    idle();
    #1;

    reset = 1'b1;
    cycle("reset");
    check("reset_valid_out", bus.valid_out, 1'b0);
    check("reset_rd_data1", bus.rd_data1, 16'h0000);
    reset = 1'b0;

    bus.rd_en = 1'b1; bus.rd_addr1 = 4'd13; bus.rd_addr2 = 4'd5;
    cycle("read_sp");
    check("sp_reset_value", bus.rd_data1, 16'h8000);
    check("r5_reset_value", bus.rd_data2, 16'h0005);
    bus.rd_addr1 = 4'd15;
    cycle("read_r15");
    check("r15_reset_value", bus.rd_data1, 16'h0000);

    bus.wr_en1 = 1'b1; bus.wr_addr1 = 4'd3; bus.wr_data1 = 16'h1234; bus.rd_addr1 = 4'd3;
    cycle("bypass_r3");
    check("bypass_r3_value", bus.rd_data1, 16'h1234);
    bus.wr_en1 = 1'b0;
    cycle("array_r3");
    check("array_r3_value", bus.rd_data1, 16'h1234);

    bus.wr_en1 = 1'b1; bus.wr_addr1 = 4'd7; bus.wr_data1 = 16'hAAAA;
    bus.wr_en2 = 1'b1; bus.wr_addr2 = 4'd7; bus.wr_data2 = 16'h5555;
    bus.rd_addr1 = 4'd7; bus.rd_addr2 = 4'd7;
    cycle("dual_wr_bypass");
    check("dual_wr_bypass_value", bus.rd_data2, 16'h5555);
    bus.wr_en1 = 1'b0; bus.wr_en2 = 1'b0;
    cycle("dual_wr_array");
    check("dual_wr_array_value", bus.rd_data1, 16'h5555);

    bus.wr_en1 = 1'b1; bus.wr_addr1 = 4'd0; bus.wr_data1 = 16'hFFFF; bus.rd_addr1 = 4'd0;
    cycle("zero_reg_write");
    check("zero_reg_bypass", bus.rd_data1, 16'h0000);
    bus.wr_en1 = 1'b0;
    cycle("zero_reg_read");
    check("zero_reg_array", bus.rd_data1, 16'h0000);

    bus.valid_in = 1'b1; bus.ls_in = 1'b1; bus.instr_in = 16'hBEEF;
    bus.rd_addr1 = 4'd1; bus.rd_addr2 = 4'd2;
    cycle("capture");
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.instr_in = 16'($urandom); bus.valid_in = 1'b0; bus.ls_in = 1'b0;
      bus.rd_addr1 = 4'($urandom); bus.rd_addr2 = 4'($urandom);
      bus.wr_en1 = (k == 1); bus.wr_addr1 = 4'd2; bus.wr_data1 = 16'h2222;
      cycle("stall_hold");
      check("stall_instr", bus.instr_out, 16'hBEEF);
      check("stall_valid", bus.valid_out, 1'b1);
      check("stall_ls", bus.ls_out, 1'b1);
    end
    bus.stall = 1'b0; bus.wr_en1 = 1'b0; bus.rd_addr2 = 4'd2;
    cycle("stall_release");
    check("write_during_stall", bus.rd_data2, 16'h2222);

    bus.stall = 1'b1; bus.flush = 1'b1; bus.rd_addr1 = 4'd9;
    cycle("stall_flush");
    check("flush_valid", bus.valid_out, 1'b0);
    check("flush_instr", bus.instr_out, 16'h0000);
    check("flush_rd_hold", bus.rd_data2, 16'h2222);
    bus.flush = 1'b0;

    reset = 1'b1;
    cycle("reset_mid_stall");
    reset = 1'b0; bus.stall = 1'b0;
    for (int i = 0; i < 16; i += 2) begin
      bus.rd_addr1 = 4'(i); bus.rd_addr2 = 4'(i + 1);
      cycle("reset_pattern");
      check("reset_pattern_even", bus.rd_data1, reset_value(i));
      check("reset_pattern_odd", bus.rd_data2, reset_value(i + 1));
    end

    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(63) == 0);
      bus.stall    = ($urandom_range(3) == 0);
      bus.flush    = ($urandom_range(7) == 0);
      bus.valid_in = 1'($urandom);
      bus.ls_in    = 1'($urandom);
      bus.instr_in = 16'($urandom);
      bus.rd_en    = ($urandom_range(3) != 0);
      bus.rd_addr1 = 4'($urandom);
      bus.rd_addr2 = 4'($urandom);
      bus.wr_en1   = 1'($urandom);
      bus.wr_en2   = 1'($urandom);
      bus.wr_addr1 = ($urandom_range(3) == 0) ? bus.rd_addr1 : 4'($urandom);
      bus.wr_addr2 = ($urandom_range(3) == 0) ? bus.wr_addr1 : 4'($urandom);
      bus.wr_data1 = 16'($urandom);
      bus.wr_data2 = 16'($urandom);
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
